rf_wb_arbiter: RTL and testbench

Write-port arbiter and buffer for the 32-entry integer register file. It shares the register file's single write port between two writeback sources: the execute-stage result (ex) and the load-return path (ld). Each source has its own small FIFO. When both FIFOs hold data, round-robin arbitration picks one of them. Optional pending-write query ports let issue logic stall readers of registers that have a write still queued.

---
 rtl/rf_wb_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the integer register file's single write port between the
//   execute-stage result (ex) and the load-return path (ld). Each source
//   is buffered in its own DEPTH-entry FIFO. When both FIFOs hold data,
//   a round-robin pointer picks the winner and flips. Writes to r0 are
//   accepted and silently dropped.
//
//   Build option: define RF_WB_PENDING_EN to enable the pending-write
//   query ports (qAddr0/1 -> qPending0/1). Without it the compare logic
//   is absent and qPending0/1 read 0.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   exValid/exReady        ex request handshake (ready = ex FIFO not full)
//   exAddr, exData         ex destination register and data
//   ldValid/ldReady        load request handshake (ready = ld FIFO not full)
//   ldAddr, ldData         load destination register and data
//   regWrite, writeAddr,   register file write port; driven only from FIFO
//   dataIn                 heads and the round-robin pointer
//   qAddr0/1, qPending0/1  "is a write to this register still queued?"
//   idle                   both FIFOs empty

`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

// Per-source writeback FIFO. Push and pop are assumed legal (the parent
// only pushes when not full and only pops when not empty).
module rf_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [AW-1:0]             addr_i,
    input  logic [DW-1:0]             data_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [AW-1:0]             head_addr_o,
    output logic [DW-1:0]             head_data_o,
    output logic [DEPTH-1:0][AW-1:0]  slot_addr_o,
    output logic [DEPTH-1:0]          slot_vld_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]            rd_q, rd_d;
    logic [PW-1:0]            wr_q, wr_d;
    logic [PW:0]              cnt_q, cnt_d;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_comb begin
        rd_d  = rd_q + PW'(pop_i);
        wr_d  = wr_q + PW'(push_i);
        cnt_d = cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push_i) begin
                addr_q[wr_q] <= addr_i;
                data_q[wr_q] <= data_i;
            end
        end
    end

    assign full_o      = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign head_addr_o = addr_q[rd_q];
    assign head_data_o = data_q[rd_q];
    assign slot_addr_o = addr_q;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        slot_vld_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_vld_o[i] = ({1'b0, PW'(i) - rd_q} < cnt_q);
        end
    end
endmodule

module rf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      exValid,
    output logic                      exReady,
    input  logic [`RF_ADDR_WIDTH-1:0] exAddr,
    input  logic [`WORD_WIDTH-1:0]    exData,
    input  logic                      ldValid,
    output logic                      ldReady,
    input  logic [`RF_ADDR_WIDTH-1:0] ldAddr,
    input  logic [`WORD_WIDTH-1:0]    ldData,
    output logic                      regWrite,
    output logic [`RF_ADDR_WIDTH-1:0] writeAddr,
    output logic [`WORD_WIDTH-1:0]    dataIn,
    input  logic [`RF_ADDR_WIDTH-1:0] qAddr0,
    input  logic [`RF_ADDR_WIDTH-1:0] qAddr1,
    output logic                      qPending0,
    output logic                      qPending1,
    output logic                      idle
);
    localparam int AW    = `RF_ADDR_WIDTH;
    localparam int DW    = `WORD_WIDTH;
    localparam int NSRC  = 2;
    localparam int SRC_EX = 0;
    localparam int SRC_LD = 1;

    // Source-indexed views: [0] = ex, [1] = ld.
    logic [NSRC-1:0]                    src_valid;
    logic [NSRC-1:0][AW-1:0]            src_addr;
    logic [NSRC-1:0][DW-1:0]            src_data;
    logic [NSRC-1:0]                    push, pop, full, empty;
    logic [NSRC-1:0][AW-1:0]            head_addr;
    logic [NSRC-1:0][DW-1:0]            head_data;
    logic [NSRC-1:0][DEPTH-1:0][AW-1:0] slot_addr;
    logic [NSRC-1:0][DEPTH-1:0]         slot_vld;

    // Round-robin pointer: 1 selects ld, 0 selects ex.
    logic rr_q, rr_d;
    logic both, any, grant_ld;

    assign src_valid = {ldValid, exValid};
    assign src_addr  = {ldAddr,  exAddr};
    assign src_data  = {ldData,  exData};

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        // Ready is purely occupancy based; an r0 write is taken but not stored.
        assign push[s] = src_valid[s] && !full[s] && (src_addr[s] != '0);

        rf_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_i      (push[s]),
            .pop_i       (pop[s]),
            .addr_i      (src_addr[s]),
            .data_i      (src_data[s]),
            .full_o      (full[s]),
            .empty_o     (empty[s]),
            .head_addr_o (head_addr[s]),
            .head_data_o (head_data[s]),
            .slot_addr_o (slot_addr[s]),
            .slot_vld_o  (slot_vld[s])
        );
    end

    assign exReady = !full[SRC_EX];
    assign ldReady = !full[SRC_LD];
    assign idle    = empty[SRC_EX] && empty[SRC_LD];

    // Grant and write port depend only on stored state, never on inputs.
    always_comb begin
        both     = !empty[SRC_EX] && !empty[SRC_LD];
        any      = !empty[SRC_EX] || !empty[SRC_LD];
        grant_ld = both ? rr_q : !empty[SRC_LD];
        pop      = '0;
        if (any) begin
            pop[SRC_LD] = grant_ld;
            pop[SRC_EX] = !grant_ld;
        end
        // Pointer only moves when it actually broke a tie.
        rr_d      = both ? !rr_q : rr_q;
        regWrite  = any;
        writeAddr = '0;
        dataIn    = '0;
        if (any) begin
            writeAddr = grant_ld ? head_addr[SRC_LD] : head_addr[SRC_EX];
            dataIn    = grant_ld ? head_data[SRC_LD] : head_data[SRC_EX];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end

`ifdef RF_WB_PENDING_EN
    // Compare against stored entries only; an enqueue this cycle is not seen.
    always_comb begin
        qPending0 = 1'b0;
        qPending1 = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_vld[s][i] && (slot_addr[s][i] == qAddr0)) qPending0 = 1'b1;
                if (slot_vld[s][i] && (slot_addr[s][i] == qAddr1)) qPending1 = 1'b1;
            end
        end
        if (qAddr0 == '0) qPending0 = 1'b0;
        if (qAddr1 == '0) qPending1 = 1'b0;
    end
`else
    assign qPending0 = 1'b0;
    assign qPending1 = 1'b0;

    logic unused_pending;
    assign unused_pending = ^{qAddr0, qAddr1, slot_addr, slot_vld};
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    localparam int DEPTH = 2;
`ifdef RF_WB_PENDING_EN
    localparam bit PEND_EN = 1'b1;
`else
    localparam bit PEND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        exValid = 1'b0, ldValid = 1'b0;
    logic [4:0]  exAddr = '0, ldAddr = '0, qAddr0 = '0, qAddr1 = '0;
    logic [31:0] exData = '0, ldData = '0;
    logic        exReady, ldReady, regWrite, qPending0, qPending1, idle;
    logic [4:0]  writeAddr;
    logic [31:0] dataIn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .exValid(exValid), .exReady(exReady), .exAddr(exAddr), .exData(exData),
        .ldValid(ldValid), .ldReady(ldReady), .ldAddr(ldAddr), .ldData(ldData),
        .regWrite(regWrite), .writeAddr(writeAddr), .dataIn(dataIn),
        .qAddr0(qAddr0), .qAddr1(qAddr1), .qPending0(qPending0), .qPending1(qPending1),
        .idle(idle)
    );

    // ---------------- reference model: two queues and a tie-break flag ----
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t exq[$];
    ent_t ldq[$];
    bit   rr_ld = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        bit ex_ne, ld_ne, ex_acc, ld_acc;
        if (!rst_n) begin
            exq.delete();
            ldq.delete();
            rr_ld = 1'b1;
        end else begin
            ex_ne  = exq.size() != 0;
            ld_ne  = ldq.size() != 0;
            ex_acc = exValid && (exq.size() < DEPTH);
            ld_acc = ldValid && (ldq.size() < DEPTH);
            if (ex_ne && ld_ne) begin
                if (rr_ld) void'(ldq.pop_front());
                else       void'(exq.pop_front());
                rr_ld = !rr_ld;
            end else if (ex_ne) begin
                void'(exq.pop_front());
            end else if (ld_ne) begin
                void'(ldq.pop_front());
            end
            if (ex_acc && exAddr != 0) exq.push_back('{exAddr, exData});
            if (ld_acc && ldAddr != 0) ldq.push_back('{ldAddr, ldData});
        end
    end

    function automatic bit pend(input logic [4:0] q);
        if (!PEND_EN || q == 0) return 1'b0;
        foreach (exq[i]) if (exq[i].a == q) return 1'b1;
        foreach (ldq[i]) if (ldq[i].a == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process: every cycle, on the falling edge ---
    always @(negedge clk) begin
        bit          any, g;
        logic [4:0]  ea;
        logic [31:0] ed;
        any = (exq.size() + ldq.size()) != 0;
        g   = (exq.size() != 0 && ldq.size() != 0) ? rr_ld : (ldq.size() != 0);
        ea  = '0;
        ed  = '0;
        if (any) begin
            ea = g ? ldq[0].a : exq[0].a;
            ed = g ? ldq[0].d : exq[0].d;
        end
        chk("m_regWrite",  regWrite,  any);
        chk("m_writeAddr", writeAddr, ea);
        chk("m_dataIn",    dataIn,    ed);
        chk("m_exReady",   exReady,   exq.size() < DEPTH);
        chk("m_ldReady",   ldReady,   ldq.size() < DEPTH);
        chk("m_idle",      idle,      !any);
        chk("m_qPending0", qPending0, pend(qAddr0));
        chk("m_qPending1", qPending1, pend(qAddr1));
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld_);
        #1;
        exValid = ev; exAddr = ea; exData = ed;
        ldValid = lv; ldAddr = la; ldData = ld_;
    endtask

    task automatic lit_wr(input string name, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({name, "_we"},   regWrite,  we);
        chk({name, "_addr"}, writeAddr, a);
        chk({name, "_data"}, dataIn,    d);
    endtask

    // Called at a falling edge; returns at a falling edge with rrPtr = ld.
    task automatic reset_dut();
        #1;
        rst_n = 1'b0;
        exValid = 0; ldValid = 0; qAddr0 = 0; qAddr1 = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_regWrite",  regWrite,  0);
        chk("rst_writeAddr", writeAddr, 0);
        chk("rst_dataIn",    dataIn,    0);
        chk("rst_idle",      idle,      1);
        chk("rst_exReady",   exReady,   1);
        chk("rst_ldReady",   ldReady,   1);
        chk("rst_qPending0", qPending0, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // single source, back-to-back
        drive(1, 5, 32'h11, 0, 0, 0); tick();
        lit_wr("single1", 1, 5, 32'h11);
        drive(1, 6, 32'h22, 0, 0, 0); tick();
        lit_wr("single2", 1, 6, 32'h22);
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("single_idle", idle, 1);

        // conflict from reset: ld wins first
        reset_dut();
        drive(1, 3, 32'hA, 1, 4, 32'hB); tick();
        lit_wr("conf1", 1, 4, 32'hB);
        drive(0, 0, 0, 0, 0, 0); tick();
        lit_wr("conf2", 1, 3, 32'hA);
        tick();
        lit_wr("conf3", 0, 0, 0);

        // backpressure: ex fills, a full FIFO refuses even while draining
        reset_dut();
        drive(1, 11, 32'h111, 1, 21, 32'h211); tick();
        lit_wr("bp1", 1, 21, 32'h211);
        drive(1, 12, 32'h112, 1, 22, 32'h212); tick();
        lit_wr("bp2", 1, 11, 32'h111);
        chk("bp2_exReady", exReady, 0);
        chk("bp2_ldReady", ldReady, 1);
        drive(1, 13, 32'h113, 0, 0, 0); tick();
        lit_wr("bp3", 1, 22, 32'h212);
        drive(0, 0, 0, 0, 0, 0); tick();
        lit_wr("bp4", 1, 12, 32'h112);
        tick();
        lit_wr("bp5", 0, 0, 0);

        // address zero is swallowed
        reset_dut();
        drive(0, 0, 0, 1, 0, 32'hDEAD); tick();
        lit_wr("r0_1", 0, 0, 0);
        chk("r0_idle", idle, 1);
        drive(0, 0, 0, 0, 0, 0); tick();
        lit_wr("r0_2", 0, 0, 0);

        // pending query
        reset_dut();
        drive(1, 3, 32'hA, 1, 7, 32'h77);
        qAddr0 = 7; qAddr1 = 3;
        tick();
        lit_wr("pend1", 1, 7, 32'h77);
        chk("pend1_q0", qPending0, PEND_EN);
        chk("pend1_q1", qPending1, PEND_EN);
        drive(0, 0, 0, 0, 0, 0); tick();
        lit_wr("pend2", 1, 3, 32'hA);
        chk("pend2_q0", qPending0, 0);
        chk("pend2_q1", qPending1, PEND_EN);
        #1 qAddr1 = 0;
        #1 chk("pend2_q1_zero", qPending1, 0);
        tick();
        chk("pend3_q1", qPending1, 0);

        // reset mid-stream: queued r1/r2 must never be written
        reset_dut();
        drive(1, 1, 32'h1, 1, 9, 32'h9); tick();
        lit_wr("mid1", 1, 9, 32'h9);
        drive(1, 2, 32'h2, 0, 0, 0); tick();
        lit_wr("mid2", 1, 1, 32'h1);
        chk("mid2_exReady", exReady, 0);
        #1 rst_n = 1'b0;
        #1;
        lit_wr("mid_rst", 0, 0, 0);
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_exReady", exReady, 1);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_after_we", regWrite, 0);
        end

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            #1;
            exValid = ($urandom_range(0, 99) < 60);
            ldValid = ($urandom_range(0, 99) < 50);
            exAddr  = 5'($urandom_range(0, 7));
            ldAddr  = 5'($urandom_range(0, 7));
            exData  = $urandom;
            ldData  = $urandom;
            qAddr0  = 5'($urandom_range(0, 7));
            qAddr1  = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
